reset_sequencer: RTL
====================

Name: reset_sequencer

Overview:
Downstream consumer of the synchronised, BUFG-buffered system reset. Releases per-subsystem resets in a fixed order, gated by clock lock, programmable delays and per-stage ready acknowledgements. Sits between the reset synchroniser output and the ECI/NIC subsystem reset inputs, all in one clock domain.

Parameters:
NUM_STAGES, 4, number of sequenced reset outputs (>=1); bit 0 is released first
HOLD_CYCLES, 16, consecutive lock-high cycles required before sequencing starts (>=1)
STAGE_DELAY, 8, cycles from entering release of a stage to deasserting its reset (>=1)
TIMEOUT_CYCLES, 1024, max wait for stage_ready; used only with RESET_SEQ_TIMEOUT_EN

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset (synchronised/buffered system reset)
lock  input  1  PLL/MMCM locked, already synchronous to clk
soft_rst  input  1  single-cycle request to re-run the sequence
stage_ready  input  NUM_STAGES  stage i finished init; sampled only while waiting on stage i
stage_rst  output  NUM_STAGES  active-high per-stage reset, registered
done  output  1  all stages released and acknowledged, registered
timeout_err  output  1  sticky ready-timeout flag; constant 0 without macro

Behaviour:
- Synchronous active-high reset on rst: state=S_HOLD, counter=0, idx=0, stage_rst=all ones, done=0, timeout_err=0.
- Priority per edge: rst > (lock==0 or soft_rst) > normal FSM.
- S_HOLD: counter increments on each edge with lock=1 and clears when lock=0. At the edge where counter==HOLD_CYCLES-1 and lock=1: counter=0, go to S_RELEASE.
- S_RELEASE: counter increments. At the edge where counter==STAGE_DELAY-1: clear stage_rst[idx] and go to S_WAIT_READY.
- S_WAIT_READY: on the edge that samples stage_ready[idx]=1:
  - if idx==NUM_STAGES-1: set done=1, go to S_DONE;
  - otherwise idx++, counter=0, go to S_RELEASE.
- S_DONE: holds; done=1, stage_rst=all zeros.
- Timing with rst low and lock high continuously: stage_rst[0] falls on edge HOLD_CYCLES+STAGE_DELAY after the first edge sampling rst=0. stage_rst[i+1] falls STAGE_DELAY edges after the edge sampling stage_ready[i]=1. done rises on the edge sampling stage_ready[NUM_STAGES-1]=1.
- stage_ready is sampled no earlier than 1 cycle after its stage is released. A ready already high is accepted on that first sample.
- Abort: lock=0 or soft_rst=1 in any state other than S_HOLD causes, on the next edge:
  - stage_rst=all ones, done=0, idx=0, counter=0, state=S_HOLD.
  - timeout_err is unaffected.
  - In S_HOLD, lock=0 only clears the counter; soft_rst also clears it.
- Ready bits of already-released stages are not monitored after acceptance. Ready bits of unreleased stages are ignored.
- stage_rst bits only ever change all-to-one (abort/reset) or one-bit-to-zero in index order. No other pattern is legal.
- Counter width: clog2 of the max of HOLD_CYCLES, STAGE_DELAY and (when enabled) TIMEOUT_CYCLES, plus 1. No wrap-around in any state.

Optional Feature:
RESET_SEQ_TIMEOUT_EN
- Defined:
  - S_WAIT_READY counts cycles while stage_ready[idx]=0.
  - At count TIMEOUT_CYCLES-1 the FSM sets timeout_err=1 (sticky, cleared only by rst) and performs an abort back to S_HOLD, re-sequencing all stages.
- Undefined:
  - S_WAIT_READY waits indefinitely.
  - timeout_err is tied to 0 and no timeout counter logic exists.

Test Plan:
1. Defaults. rst released, lock=1, stage_ready tied to ~stage_rst → stage_rst[0] falls at edge 24, [1] at 33, [2] at 42, [3] at 51; done=1 after edge 52; stage_rst=4'b0000 thereafter.
2. lock=0 until edge 10 and then high, with a single-cycle lock=0 glitch at edge 18 → hold count restarts; stage_rst[0] falls 24 edges after lock re-asserts; no stage releases early.
3. After done, drop lock for 1 cycle → next edge stage_rst=4'b1111, done=0; full sequence repeats with test-1 spacing once lock returns.
4. soft_rst pulse while waiting on stage 2 (stage_rst=4'b1100) → next edge stage_rst=4'b1111, idx=0; re-sequence completes normally.
5. stage_ready[1] held 0:
   - macro undefined: stage_rst stays 4'b1100 for 5000 cycles, timeout_err=0;
   - macro defined: after 1024 wait cycles timeout_err=1, stage_rst=4'b1111, and sequencing restarts.
6. Assert rst mid-sequence with timeout_err=1 → next edge all outputs at reset values, timeout_err=0.

Source files
------------

// File: rtl/reset_sequencer.sv
// Ordered per-stage reset release gated by clock lock, programmable delays and ready acks.
// Optional RESET_SEQ_TIMEOUT_EN adds a sticky ready-timeout flag with automatic re-sequencing.
module reset_sequencer #(
    parameter int unsigned NUM_STAGES     = 4,
    parameter int unsigned HOLD_CYCLES    = 16,
    parameter int unsigned STAGE_DELAY    = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lock,
    input  logic                  soft_rst,
    input  logic [NUM_STAGES-1:0] stage_ready,
    output logic [NUM_STAGES-1:0] stage_rst,
    output logic                  done,
    output logic                  timeout_err
);

    localparam int unsigned MAX_HS = (HOLD_CYCLES > STAGE_DELAY) ? HOLD_CYCLES : STAGE_DELAY;
`ifdef RESET_SEQ_TIMEOUT_EN
    localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > MAX_HS) ? TIMEOUT_CYCLES : MAX_HS;
`else
    localparam int unsigned CNT_MAX = MAX_HS;
`endif
    localparam int unsigned CNT_W = $clog2(CNT_MAX) + 1;
    localparam int unsigned IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(STAGE_DELAY - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_STAGES - 1);

    // Elaboration-time guard against degenerate configurations
    if (NUM_STAGES < 1 || HOLD_CYCLES < 1 || STAGE_DELAY < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("reset_sequencer: all parameters must be >= 1");
    end

    typedef enum logic [1:0] {
        S_HOLD       = 2'd0,
        S_RELEASE    = 2'd1,
        S_WAIT_READY = 2'd2,
        S_DONE       = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NUM_STAGES-1:0]   stage_rst_q, stage_rst_d;
    logic                    done_q, done_d;
    logic                    abort_c;

    assign abort_c = ~lock | soft_rst;

`ifdef RESET_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic timeout_err_q, timeout_err_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_HOLD;
            cnt_q       <= '0;
            idx_q       <= '0;
            stage_rst_q <= '1;
            done_q      <= 1'b0;
`ifdef RESET_SEQ_TIMEOUT_EN
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            stage_rst_q <= stage_rst_d;
            done_q      <= done_d;
`ifdef RESET_SEQ_TIMEOUT_EN
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        stage_rst_d = stage_rst_q;
        done_d      = done_q;
`ifdef RESET_SEQ_TIMEOUT_EN
        timeout_err_d = timeout_err_q;
`endif

        if (state_q != S_HOLD && abort_c) begin
            // Lost lock or software request: put every stage back in reset
            state_d     = S_HOLD;
            cnt_d       = '0;
            idx_d       = '0;
            stage_rst_d = '1;
            done_d      = 1'b0;
        end else begin
            case (state_q)
                S_HOLD: begin
                    if (abort_c) begin
                        cnt_d = '0;
                    end else if (cnt_q == HOLD_LAST) begin
                        cnt_d   = '0;
                        state_d = S_RELEASE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                S_RELEASE: begin
                    if (cnt_q == DELAY_LAST) begin
                        stage_rst_d[idx_q] = 1'b0;
                        cnt_d              = '0;
                        state_d            = S_WAIT_READY;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                S_WAIT_READY: begin
                    if (stage_ready[idx_q]) begin
                        cnt_d = '0;
                        if (idx_q == IDX_LAST) begin
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = S_RELEASE;
                        end
                    end
`ifdef RESET_SEQ_TIMEOUT_EN
                    // Stage never acknowledged: flag it and re-sequence from scratch
                    else if (cnt_q == TO_LAST) begin
                        timeout_err_d = 1'b1;
                        state_d       = S_HOLD;
                        cnt_d         = '0;
                        idx_d         = '0;
                        stage_rst_d   = '1;
                        done_d        = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end

                S_DONE: begin
                    done_d      = 1'b1;
                    stage_rst_d = '0;
                end

                default: begin
                    state_d     = S_HOLD;
                    cnt_d       = '0;
                    idx_d       = '0;
                    stage_rst_d = '1;
                    done_d      = 1'b0;
                end
            endcase
        end
    end

    assign stage_rst = stage_rst_q;
    assign done      = done_q;
`ifdef RESET_SEQ_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule
